// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//   APB initiator. Takes single read/write commands from a local controller,
//   runs each one as an APB SETUP/ACCESS transfer to one of two responders,
//   and returns the read data or a timeout error.
//   The address MSB selects the responder: 0 = slave 1, 1 = slave 2.
//
// Ports
//   PCLK, PRESETn          clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only while IDLE)
//   cmd_write/addr/wdata   command direction, target address, write data
//   rsp_valid              one-cycle pulse when a transfer has finished
//   rsp_rdata              read data (valid with rsp_valid for a good read)
//   rsp_err                qualified by rsp_valid; 1 = timeout abort
//   PSEL1/PSEL2            responder selects (never both high)
//   PENABLE, PWRITE        APB enable and direction
//   PADDR, PWDATA          APB address and write data
//   PREADY1/2, PRDATA1/2   ready and read data from each responder
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY1,
  input  logic              PREADY2,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e              state_q,     state_d;
  logic                psel1_q,     psel1_d;
  logic                psel2_q,     psel2_d;
  logic                penable_q,   penable_d;
  logic                pwrite_q,    pwrite_d;
  logic [ADDR_W-1:0]   paddr_q,     paddr_d;
  logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q,   rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;

  // Only the selected responder is listened to; the other one is don't-care.
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;

  assign sel_ready = psel2_q ? PREADY2 : PREADY1;
  assign sel_rdata = psel2_q ? PRDATA2 : PRDATA1;

  always_comb begin
    // NOTE: every signal written here gets its hold/default value first, so
    // no path through the case statement can leave one unassigned (no latch).
    state_d     = state_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel1_d   = ~cmd_addr[ADDR_W-1];
          psel2_d   =  cmd_addr[ADDR_W-1];
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (sel_ready) begin
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          if (!pwrite_q) begin
            rsp_rdata_d = sel_rdata;
          end
          state_d     = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abort: rsp_rdata keeps its previous value.
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!PRESETn) begin
      state_q     <= IDLE;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // The only combinational output: forced low while reset is asserted.
  assign cmd_ready = (state_q == IDLE) && PRESETn;

  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//   Self-checking bench for apb_master. Each command is expanded into its
//   expected cycle timeline (SETUP, ACCESS cycles, response) from the
//   responder's planned wait count; a memory array stands in for both slaves.
// -----------------------------------------------------------------------------
module tb_apb_master;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL1, PSEL2, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY1, PREADY2;
  logic [DATA_W-1:0] PRDATA1, PRDATA2;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL1     (PSEL1),
    .PSEL2     (PSEL2),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PREADY1   (PREADY1),
    .PREADY2   (PREADY2),
    .PRDATA1   (PRDATA1),
    .PRDATA2   (PRDATA2)
  );

  // ---------------- model state (written by the stimulus process) ----------
  logic              exp_cmd_ready, exp_psel1, exp_psel2, exp_penable;
  logic              exp_pwrite, exp_rsp_valid, exp_rsp_err;
  logic [ADDR_W-1:0] exp_paddr;
  logic [DATA_W-1:0] exp_pwdata, exp_rsp_rdata;
  logic              chk_en  = 1'b0;
  logic              chk_err = 1'b0;
  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Literal expectations handed to the compare process for one cycle.
  string             pin_name [4];
  logic [31:0]       pin_act  [4];
  logic [31:0]       pin_exp  [4];
  int                n_pin = 0;

  // ---------------- compare process ----------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cnt_psel1 = 0, cnt_psel2 = 0, cnt_pen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge PCLK) begin
    if (chk_en) begin
      check("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
      check("PSEL1",     32'(PSEL1),     32'(exp_psel1));
      check("PSEL2",     32'(PSEL2),     32'(exp_psel2));
      check("PENABLE",   32'(PENABLE),   32'(exp_penable));
      check("PWRITE",    32'(PWRITE),    32'(exp_pwrite));
      check("PADDR",     32'(PADDR),     32'(exp_paddr));
      check("PWDATA",    32'(PWDATA),    32'(exp_pwdata));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rsp_rdata));
      check("psel_excl", 32'(PSEL1 & PSEL2), 32'd0);
      if (chk_err) check("rsp_err", 32'(rsp_err), 32'(exp_rsp_err));
      for (int i = 0; i < n_pin; i++) check(pin_name[i], pin_act[i], pin_exp[i]);
      cnt_psel1 += int'(PSEL1);
      cnt_psel2 += int'(PSEL2);
      cnt_pen   += int'(PENABLE);
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step();
    @(posedge PCLK);
    #1;
    n_pin = 0;
  endtask

  task automatic pin(input string nm, input logic [31:0] a, input logic [31:0] e);
    if (n_pin < 4) begin
      pin_name[n_pin] = nm;
      pin_act[n_pin]  = a;
      pin_exp[n_pin]  = e;
      n_pin++;
    end
  endtask

  task automatic exp_reset(input logic released);
    exp_cmd_ready = released;
    exp_psel1     = 1'b0;
    exp_psel2     = 1'b0;
    exp_penable   = 1'b0;
    exp_pwrite    = 1'b0;
    exp_paddr     = '0;
    exp_pwdata    = '0;
    exp_rsp_valid = 1'b0;
    exp_rsp_err   = 1'b0;
    exp_rsp_rdata = '0;
    chk_err       = 1'b1;
  endtask

  // Garbage on inputs the master must ignore in the current state.
  task automatic noise(input logic allow_cmd, input logic force_ready);
    cmd_valid = allow_cmd ? 1'($urandom % 2) : 1'b0;
    cmd_write = 1'($urandom % 2);
    cmd_addr  = ADDR_W'($urandom);
    cmd_wdata = DATA_W'($urandom);
    PREADY1   = force_ready ? 1'b1 : 1'($urandom % 2);
    PREADY2   = force_ready ? 1'b1 : 1'($urandom % 2);
    PRDATA1   = DATA_W'($urandom);
    PRDATA2   = DATA_W'($urandom);
  endtask

  task automatic idle_cycle();
    noise(1'b0, 1'b0);
    step();
    exp_cmd_ready = 1'b1;
    exp_psel1     = 1'b0;
    exp_psel2     = 1'b0;
    exp_penable   = 1'b0;
    exp_rsp_valid = 1'b0;
    chk_err       = 1'b0;
  endtask

  // Runs one command from the current (idle) cycle. wait_n = number of
  // ACCESS cycles with PREADY low before it rises; rst_at >= 0 asserts reset
  // in that ACCESS cycle. Returns in the response cycle (or the cycle after
  // the reset edge).
  task automatic do_txn(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input int wait_n, input int rst_at);
    logic sel2;
    logic done, tout;
    sel2 = addr[ADDR_W-1];
    done = 1'b0;
    tout = 1'b0;

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    step();

    // SETUP: ready forced high to prove stale PREADY is ignored here.
    exp_cmd_ready = 1'b0;
    exp_psel1     = ~sel2;
    exp_psel2     = sel2;
    exp_penable   = 1'b0;
    exp_pwrite    = wr;
    exp_paddr     = addr;
    exp_pwdata    = wd;
    exp_rsp_valid = 1'b0;
    chk_err       = 1'b0;
    noise(1'b1, 1'b1);
    step();

    for (int i = 0; i < TIMEOUT; i++) begin
      exp_penable = 1'b1;
      noise(1'b1, 1'b0);
      if (i == rst_at) begin
        PRESETn = 1'b0;
        PREADY1 = 1'b0;
        PREADY2 = 1'b0;
        step();
        PRESETn   = 1'b1;
        cmd_valid = 1'b0;
        exp_reset(1'b1);
        return;
      end
      done = (i == wait_n);
      tout = !done && (i == TIMEOUT - 1);
      if (sel2) begin
        PREADY2 = done;
        PRDATA2 = mem[addr];
        PREADY1 = 1'b1;
        PRDATA1 = ~mem[addr];
      end else begin
        PREADY1 = done;
        PRDATA1 = mem[addr];
        PREADY2 = 1'b1;
        PRDATA2 = ~mem[addr];
      end
      step();
      if (done || tout) break;
    end

    exp_cmd_ready = 1'b1;
    exp_psel1     = 1'b0;
    exp_psel2     = 1'b0;
    exp_penable   = 1'b0;
    exp_rsp_valid = 1'b1;
    exp_rsp_err   = tout;
    chk_err       = 1'b1;
    if (done && !wr) exp_rsp_rdata = mem[addr];
    if (done && wr)  mem[addr] = wd;
    noise(1'b0, 1'b0);
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin : main
    int s1, s2, se;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    int                r_wait, r_rst, r_sel;
    logic [ADDR_W-1:0] pool [5];

    pool[0] = 9'h011; pool[1] = 9'h105; pool[2] = 9'h03C;
    pool[3] = 9'h1FF; pool[4] = 9'h000;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = DATA_W'($urandom);

    // Reset held for 3 edges with a command presented.
    PRESETn   = 1'b0;
    noise(1'b0, 1'b0);
    cmd_valid = 1'b1;
    exp_reset(1'b0);
    step();
    chk_en = 1'b1;
    step();
    step();
    PRESETn   = 1'b1;
    cmd_valid = 1'b0;
    exp_reset(1'b1);
    idle_cycle();

    // Write 0x105 = 0xA5 to slave 2, PREADY one cycle after PENABLE.
    s1 = cnt_psel1; s2 = cnt_psel2; se = cnt_pen;
    do_txn(1'b1, 9'h105, 8'hA5, 1, -1);
    pin("wr_psel2_cycles", 32'(cnt_psel2 - s2), 32'd3);
    pin("wr_penable_cycles", 32'(cnt_pen - se), 32'd2);
    pin("wr_psel1_cycles", 32'(cnt_psel1 - s1), 32'd0);
    pin("wr_rsp_err", 32'(rsp_err), 32'd0);
    idle_cycle();

    // Read 0x03C from slave 1 after 3 wait cycles.
    mem[9'h03C] = 8'h5E;
    se = cnt_pen;
    do_txn(1'b0, 9'h03C, 8'h00, 3, -1);
    pin("rd_penable_cycles", 32'(cnt_pen - se), 32'd4);
    pin("rd_rdata", 32'(rsp_rdata), 32'h5E);
    idle_cycle();

    // Timeout on slave 2.
    s2 = cnt_psel2; se = cnt_pen;
    do_txn(1'b0, 9'h120, 8'h00, 1000, -1);
    pin("to_penable_cycles", 32'(cnt_pen - se), 32'd16);
    pin("to_psel2_cycles", 32'(cnt_psel2 - s2), 32'd17);
    pin("to_rsp_err", 32'(rsp_err), 32'd1);
    pin("to_rdata_kept", 32'(rsp_rdata), 32'h5E);
    idle_cycle();

    // Back-to-back write then read of 0x011.
    do_txn(1'b1, 9'h011, 8'h77, 0, -1);
    do_txn(1'b0, 9'h011, 8'h00, 0, -1);
    pin("b2b_rdata", 32'(rsp_rdata), 32'h77);
    idle_cycle();

    // Reset in the middle of a pending read.
    do_txn(1'b0, 9'h03C, 8'h00, 10, 2);
    pin("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    idle_cycle();

    // Randomized commands.
    for (int t = 0; t < 150; t++) begin
      r_wr   = 1'($urandom % 2);
      r_addr = ($urandom % 2 == 0) ? pool[$urandom % 5] : ADDR_W'($urandom);
      r_sel  = int'($urandom % 10);
      case (r_sel)
        6:       r_wait = TIMEOUT - 1;
        7:       r_wait = TIMEOUT;
        8:       r_wait = TIMEOUT + 5;
        9:       r_wait = int'($urandom % 8);
        default: r_wait = int'($urandom % 4);
      endcase
      r_rst = (!r_wr && r_wait > 2 && ($urandom % 6 == 0)) ? 1 : -1;
      do_txn(r_wr, r_addr, DATA_W'($urandom), r_wait, r_rst);
      repeat (int'($urandom % 3)) idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    @(negedge PCLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
